// File: rtl/pio_bus_master.sv
// -----------------------------------------------------------------------------
// pio_bus_master
//
// Avalon-MM initiator for single-register PIO slaves. FPGA-side logic (the
// SHA256 control FSM) hands it one command at a time; it runs a write, a
// single read, or a poll-until-match sequence on the PIO bus. It then returns
// exactly one response per command.
//
// Ports
//   clk, reset_n      system clock, asynchronous active-low reset
//   cmd_valid/ready   command handshake (see below)
//   cmd_op            00 write, 01 read, 10 poll, 11 reserved (illegal)
//   cmd_addr          target register address
//   cmd_wdata         write data (write) or compare value (poll)
//   cmd_mask          poll compare mask
//   cmd_limit         maximum poll reads, 0 = unlimited
//   rsp_valid         one-cycle response strobe
//   rsp_data          read data / last polled sample, 0 for write and illegal
//   rsp_status        00 ok, 01 poll timeout, 10 illegal op
//   address, chipselect, write_n, writedata, readdata
//                     PIO slave bus (all outputs registered)
//   fsm_state         current controller state, for debug and checkers
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE, and it is
// combinational from the state register. While busy, cmd_valid is ignored and
// the command fields may change freely. The response side has no backpressure:
// rsp_valid pulses for one cycle, and rsp_data/rsp_status hold until the next
// response.
//
// RD_LATENCY (legal range 1-4) is the number of cycles from the read-issue
// cycle to the cycle in which readdata is valid.
// -----------------------------------------------------------------------------
module pio_bus_master #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    input  logic [DATA_W-1:0]    cmd_mask,
    input  logic [TIMEOUT_W-1:0] cmd_limit,

    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_data,
    output logic [1:0]           rsp_status,

    output logic [ADDR_W-1:0]    address,
    output logic                 chipselect,
    output logic                 write_n,
    output logic [DATA_W-1:0]    writedata,
    input  logic [DATA_W-1:0]    readdata,

    output logic [2:0]           fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;

    // Wait counter runs 1..RD_LATENCY. Three bits cover the legal range.
    localparam logic [2:0]           LAT      = 3'(RD_LATENCY);
    localparam logic [TIMEOUT_W-1:0] ITER_MAX = '1;

    state_t               state;
    logic [1:0]           op_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    mask_q;
    logic [TIMEOUT_W-1:0] limit_q;
    logic [TIMEOUT_W-1:0] iter_q;
    logic [2:0]           wait_cnt;

    logic sample_now;
    logic poll_match;
    logic poll_expired;

    assign cmd_ready = (state == IDLE);
    assign fsm_state = state;

    // readdata is valid exactly RD_LATENCY cycles after the issue cycle.
    // The first RD_WAIT cycle is issue + 1, so it is the sample cycle when
    // wait_cnt == 1.
    assign sample_now   = (wait_cnt == LAT);
    assign poll_match   = ((readdata & mask_q) == (wdata_q & mask_q));
    // iter_q has already been bumped for the read being sampled.
    // A limit of 0 means the poll never times out.
    assign poll_expired = (limit_q != '0) && (iter_q == limit_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op_q       <= OP_WRITE;
            wdata_q    <= '0;
            mask_q     <= '0;
            limit_q    <= '0;
            iter_q     <= '0;
            wait_cnt   <= '0;
            address    <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_status <= ST_OK;
        end else begin
            // RESP lasts one cycle, so clearing the strobe by default gives
            // the one-cycle pulse.
            rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        wdata_q <= cmd_wdata;
                        mask_q  <= cmd_mask;
                        limit_q <= cmd_limit;
                        iter_q  <= '0;
                        case (cmd_op)
                            OP_WRITE: begin
                                state      <= WR;
                                address    <= cmd_addr;
                                chipselect <= 1'b1;
                                write_n    <= 1'b0;
                                writedata  <= cmd_wdata;
                            end
                            OP_READ, OP_POLL: begin
                                state      <= RD_ISSUE;
                                address    <= cmd_addr;
                                chipselect <= 1'b1;
                                write_n    <= 1'b1;
                            end
                            default: begin
                                // Reserved op: answer straight away.
                                // Nothing is driven on the bus.
                                state      <= RESP;
                                rsp_valid  <= 1'b1;
                                rsp_data   <= '0;
                                rsp_status <= ST_ILLEGAL;
                            end
                        endcase
                    end
                end

                WR: begin
                    state      <= RESP;
                    chipselect <= 1'b0;
                    write_n    <= 1'b1;
                    rsp_valid  <= 1'b1;
                    rsp_data   <= '0;
                    rsp_status <= ST_OK;
                end

                RD_ISSUE: begin
                    state      <= RD_WAIT;
                    chipselect <= 1'b0;
                    wait_cnt   <= 3'd1;
                    if (iter_q != ITER_MAX) begin
                        iter_q <= iter_q + 1'b1;
                    end
                end

                RD_WAIT: begin
                    if (sample_now) begin
                        if ((op_q == OP_READ) || poll_match) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= readdata;
                            rsp_status <= ST_OK;
                        end else if (poll_expired) begin
                            state      <= RESP;
                            rsp_valid  <= 1'b1;
                            rsp_data   <= readdata;
                            rsp_status <= ST_TIMEOUT;
                        end else begin
                            // Reissue. address is still held from IDLE, so
                            // the poll period is RD_LATENCY + 1 cycles.
                            state      <= RD_ISSUE;
                            chipselect <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_bus_master.sv
// -----------------------------------------------------------------------------
// tb_pio_bus_master
//
// Self-checking bench for pio_bus_master (default parameters, RD_LATENCY = 1).
// The driver computes each command's expected bus cycles and response from a
// small reference model of the slave read sequence. It pushes them to
// scoreboard queues. A negedge monitor pops and compares whenever the DUT
// drives the bus or strobes a response.
// -----------------------------------------------------------------------------
module tb_pio_bus_master;

    localparam int ADDR_W     = 2;
    localparam int DATA_W     = 32;
    localparam int RD_LATENCY = 1;
    localparam int TIMEOUT_W  = 16;
    localparam int PERIOD     = RD_LATENCY + 1;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = '0;
    logic [ADDR_W-1:0]    cmd_addr = '0;
    logic [DATA_W-1:0]    cmd_wdata = '0;
    logic [DATA_W-1:0]    cmd_mask = '0;
    logic [TIMEOUT_W-1:0] cmd_limit = '0;
    logic                 rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic [1:0]           rsp_status;
    logic [ADDR_W-1:0]    address;
    logic                 chipselect;
    logic                 write_n;
    logic [DATA_W-1:0]    writedata;
    logic [DATA_W-1:0]    readdata = '0;
    logic [2:0]           fsm_state;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    // Scoreboard queues
    logic [31:0]       exp_rsp_cyc[$];
    logic [DATA_W-1:0] exp_rsp_data[$];
    logic [1:0]        exp_rsp_status[$];
    logic [31:0]       exp_bus_cyc[$];
    logic              exp_bus_wn[$];
    logic [ADDR_W-1:0] exp_bus_addr[$];
    logic [DATA_W-1:0] exp_bus_wdata[$];

    // Slave model state
    logic [DATA_W-1:0] slave_q[$];
    logic [DATA_W-1:0] slave_default = '0;
    logic [DATA_W-1:0] last_wdata = '0;

    logic [1:0]           r_op;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_mask;
    logic [TIMEOUT_W-1:0] r_limit;

    pio_bus_master #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LATENCY (RD_LATENCY),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_mask   (cmd_mask),
        .cmd_limit  (cmd_limit),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got time-limit exp finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- check task ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- PIO slave model: registered readdata ----------------
    always @(posedge clk) begin
        if (reset_n && chipselect && write_n) begin
            if (slave_q.size() > 0) readdata <= slave_q.pop_front();
            else                    readdata <= slave_default;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (chipselect || !write_n) begin
                if (exp_bus_cyc.size() == 0) begin
                    check_eq("bus_unexp", {62'b0, chipselect, write_n}, 64'b01);
                end else begin
                    check_eq("bus_cycle", cyc, exp_bus_cyc.pop_front());
                    check_eq("bus_cs", chipselect, 1'b1);
                    check_eq("bus_write_n", write_n, exp_bus_wn.pop_front());
                    check_eq("bus_addr", address, exp_bus_addr.pop_front());
                    check_eq("bus_wdata", writedata, exp_bus_wdata.pop_front());
                end
            end
            if (rsp_valid) begin
                if (exp_rsp_cyc.size() == 0) begin
                    check_eq("rsp_unexp", rsp_valid, 1'b0);
                end else begin
                    check_eq("rsp_cycle", cyc, exp_rsp_cyc.pop_front());
                    check_eq("rsp_data", rsp_data, exp_rsp_data.pop_front());
                    check_eq("rsp_status", rsp_status, exp_rsp_status.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge. Presents the command and waits (bounded) for
    // cmd_ready. It then records expectations and returns at the following
    // negedge. cmd_valid is left high; the caller drops it or overwrites the
    // fields.
    task automatic issue_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] mask,
                             input logic [TIMEOUT_W-1:0] limit);
        int          guard;
        int          n_reads;
        bit          done;
        int unsigned t;
        logic [DATA_W-1:0] sample;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_mask  = mask;
        cmd_limit = limit;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            check_eq("ready_wait", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        t = cyc;
        case (op)
            2'b00: begin
                exp_bus_cyc.push_back(t + 1);
                exp_bus_wn.push_back(1'b0);
                exp_bus_addr.push_back(addr);
                exp_bus_wdata.push_back(wdata);
                last_wdata = wdata;
                exp_rsp_cyc.push_back(t + 2);
                exp_rsp_data.push_back('0);
                exp_rsp_status.push_back(2'b00);
            end
            2'b01, 2'b10: begin
                n_reads = 0;
                done = 1'b0;
                while (!done && n_reads < 64) begin
                    sample = (n_reads < slave_q.size()) ? slave_q[n_reads] : slave_default;
                    exp_bus_cyc.push_back(t + 1 + PERIOD * n_reads);
                    exp_bus_wn.push_back(1'b1);
                    exp_bus_addr.push_back(addr);
                    exp_bus_wdata.push_back(last_wdata);
                    n_reads++;
                    if (op == 2'b01 || ((sample & mask) == (wdata & mask))) begin
                        done = 1'b1;
                        exp_rsp_data.push_back(sample);
                        exp_rsp_status.push_back(2'b00);
                    end else if (limit != '0 && n_reads == int'(limit)) begin
                        done = 1'b1;
                        exp_rsp_data.push_back(sample);
                        exp_rsp_status.push_back(2'b01);
                    end
                end
                if (done) exp_rsp_cyc.push_back(t + 1 + PERIOD * (n_reads - 1) + RD_LATENCY + 1);
            end
            default: begin
                exp_rsp_cyc.push_back(t + 1);
                exp_rsp_data.push_back('0);
                exp_rsp_status.push_back(2'b10);
            end
        endcase
        @(negedge clk);
    endtask

    task automatic drop_cmd();
        cmd_valid = 1'b0;
    endtask

    // Waits for n response strobes. The DUT must stay not-ready all the way
    // through, then be ready on the cycle after the last RESP.
    task automatic wait_drain(input int n);
        int guard;
        int seen;
        guard = 0;
        seen  = 0;
        while (seen < n && guard < 500) begin
            check_eq("busy_ready", cmd_ready, 1'b0);
            if (rsp_valid) seen++;
            if (seen < n) @(negedge clk);
            guard++;
        end
        if (seen < n) check_eq("rsp_timeout", seen, n);
        @(negedge clk);
        check_eq("ready_after", cmd_ready, 1'b1);
    endtask

    task automatic flush_expect();
        exp_rsp_cyc.delete();
        exp_rsp_data.delete();
        exp_rsp_status.delete();
        exp_bus_cyc.delete();
        exp_bus_wn.delete();
        exp_bus_addr.delete();
        exp_bus_wdata.delete();
        slave_q.delete();
        last_wdata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rst_address", address, 0);
        check_eq("rst_cs", chipselect, 1'b0);
        check_eq("rst_write_n", write_n, 1'b1);
        check_eq("rst_writedata", writedata, 0);
        check_eq("rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_status", rsp_status, 0);
        check_eq("rst_ready", cmd_ready, 1'b1);
        @(negedge clk);

        // 1: write
        issue_cmd(2'b00, 2'd0, 32'h1, 32'h0, 16'd0); drop_cmd(); wait_drain(1);
        // 2: read
        slave_q.push_back(32'h0000_0001);
        issue_cmd(2'b01, 2'd0, 32'h0, 32'h0, 16'd0); drop_cmd(); wait_drain(1);
        // 3: poll, bit0 rises on the third read
        slave_q.push_back(32'h0); slave_q.push_back(32'h0); slave_q.push_back(32'h1);
        issue_cmd(2'b10, 2'd0, 32'h1, 32'h1, 16'd5); drop_cmd(); wait_drain(1);
        // 4: poll times out after 4 reads
        slave_default = 32'h0;
        issue_cmd(2'b10, 2'd0, 32'h1, 32'h1, 16'd4); drop_cmd(); wait_drain(1);
        // limit = 1 times out on the first non-matching sample
        slave_q.push_back(32'h2);
        issue_cmd(2'b10, 2'd1, 32'h1, 32'h1, 16'd1); drop_cmd(); wait_drain(1);
        // mask = 0 matches on the first read
        slave_q.push_back(32'hDEAD_BEEF);
        issue_cmd(2'b10, 2'd3, 32'h1234, 32'h0, 16'd3); drop_cmd(); wait_drain(1);
        // 5: illegal op
        issue_cmd(2'b11, 2'd1, 32'h55, 32'h0, 16'd0); drop_cmd(); wait_drain(1);
        // 5b: cmd_valid held through a busy poll; the write waits for IDLE
        slave_q.push_back(32'h0); slave_q.push_back(32'h3);
        issue_cmd(2'b10, 2'd1, 32'h1, 32'h1, 16'd0);
        issue_cmd(2'b00, 2'd2, 32'hA5A5_0003, 32'h0, 16'd0);
        drop_cmd(); wait_drain(1);

        // random mix
        for (int i = 0; i < 12; i++) begin
            r_op    = 2'($urandom_range(0, 3));
            r_addr  = 2'($urandom_range(0, 3));
            r_wdata = $urandom;
            r_mask  = $urandom;
            r_limit = 16'($urandom_range(1, 3));
            if (r_op == 2'b01) slave_q.push_back($urandom);
            if (r_op == 2'b10) for (int j = 0; j < 3; j++) slave_q.push_back($urandom);
            issue_cmd(r_op, r_addr, r_wdata, r_mask, r_limit); drop_cmd(); wait_drain(1);
        end
        slave_q.delete();

        // unlimited poll matches on the sixth read
        for (int j = 0; j < 5; j++) slave_q.push_back(32'h0);
        slave_q.push_back(32'h11);
        issue_cmd(2'b10, 2'd2, 32'h1, 32'h1, 16'd0); drop_cmd(); wait_drain(1);
        // make sure writedata is non-zero before the reset test
        issue_cmd(2'b00, 2'd1, 32'hCAFE_0001, 32'h0, 16'd0); drop_cmd(); wait_drain(1);
        slave_q.push_back(32'h0000_00F0);
        issue_cmd(2'b01, 2'd3, 32'h0, 32'h0, 16'd0); drop_cmd(); wait_drain(1);

        // 6: reset pulsed during RD_WAIT of an unlimited poll
        slave_default = 32'h0;
        issue_cmd(2'b10, 2'd2, 32'h1, 32'h1, 16'd0); drop_cmd();
        @(negedge clk);
        check_eq("pre_rst_state", fsm_state, 3'd3);
        check_eq("pre_rst_addr", address, 2'd2);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_cs", chipselect, 1'b0);
        check_eq("mid_rst_write_n", write_n, 1'b1);
        check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check_eq("mid_rst_address", address, 0);
        check_eq("mid_rst_writedata", writedata, 0);
        check_eq("mid_rst_rsp_data", rsp_data, 0);
        check_eq("mid_rst_rsp_status", rsp_status, 0);
        flush_expect();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("ready_release", cmd_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check_eq("quiet_rsp", rsp_valid, 1'b0);
            check_eq("quiet_cs", chipselect, 1'b0);
        end
        issue_cmd(2'b00, 2'd0, 32'h1, 32'h0, 16'd0); drop_cmd(); wait_drain(1);

        repeat (4) @(negedge clk);
        check_eq("rsp_left", exp_rsp_cyc.size(), 0);
        check_eq("bus_left", exp_bus_cyc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
